iobuf_bus_sequencer: RTL and testbench
======================================

// Module: iobuf_bus_sequencer
// PURPOSE
// - Logic-side controller for a WIDTH-bit bidirectional pad bus built from per-bit tri-state IO buffers.
// - Drives buffer data (pad_i) and enable (pad_t), and samples the buffer readback (pad_o).
// - Turns single read/write requests into bus cycles, inserting turnaround gaps so the two ends never drive together.
// - Sits between a PicoBlaze port-decode block and the pad ring.
// PARAMETERS
// WIDTH        8  bus width; each bit maps to one IO buffer
// TURN_CYCLES  2  released-bus cycles on a direction change (>=1)
// DRIVE_CYCLES 2  cycles write data is held before ack (>=1)
// SYNC_STAGES  2  flops in pad_o synchroniser (>=2)
// PORTS
// clk        in   1      rising-edge clock
// rst_n      in   1      async active-low reset
// req_valid  in   1      request present
// req_ready  out  1      controller idle, request accepted when req_valid&req_ready
// req_write  in   1      1=write, 0=read; sampled at accept
// req_wdata  in   WIDTH  write data; sampled at accept
// rsp_valid  out  1      one-cycle completion pulse, no backpressure
// rsp_rdata  out  WIDTH  read data, valid with rsp_valid; 0 for write acks
// pad_i      out  WIDTH  to IO buffer I inputs
// pad_t      out  1      to all IO buffer T inputs; 1=released (hi-Z), 0=driving
// pad_o      in   WIDTH  from IO buffer O outputs (async to clk)
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state=IDLE, dir=RELEASED, pad_t=1, pad_i=0, req_ready=1.
//   - rsp_valid=0, rsp_rdata=0, synchroniser flops=0, counters=0.
//   - pad_t goes 1 immediately, even mid-drive.
// - States: IDLE, TURN, DRIVE, SAMPLE, RESP. All outputs are registered.
// - req_ready=1 only in IDLE. Requests while busy are not accepted and must be held by the source.
// - E0 = the accept edge. Accept: IDLE and req_valid=1; latch req_write and req_wdata.
// - Write, dir=DRIVING:
//   - At E0: IDLE->DRIVE, pad_i<=wdata.
//   - Hold DRIVE_CYCLES cycles, ->RESP.
//   - rsp_valid=1 from edge E0+DRIVE_CYCLES.
// - Write, dir=RELEASED:
//   - At E0: IDLE->TURN, pad_t stays 1 for TURN_CYCLES.
//   - At E0+TURN_CYCLES: pad_i<=wdata, pad_t<=0, dir<=DRIVING, ->DRIVE.
//   - rsp_valid from edge E0+TURN_CYCLES+DRIVE_CYCLES.
// - Read, dir=DRIVING:
//   - At E0: pad_t<=1, dir<=RELEASED, ->TURN for TURN_CYCLES.
//   - Then ->SAMPLE for SYNC_STAGES cycles.
//   - rsp_valid from edge E0+TURN_CYCLES+SYNC_STAGES, rsp_rdata = synchroniser output at that edge.
// - Read, dir=RELEASED: skip TURN; rsp_valid from edge E0+SYNC_STAGES.
// - After a write the bus stays driven with the last pad_i until a read arrives, so write->write needs no turnaround.
// - pad_i holds its value while released; it changes only on a drive edge.
// - RESP lasts exactly 1 cycle, then ->IDLE. req_ready returns 1 on the edge after the rsp_valid pulse.
// - pad_o is always synchronised through SYNC_STAGES flops. It is never used unsynchronised.
// - pad_t and pad_i never change in the same edge as a release-to-drive turn without TURN_CYCLES released cycles first.
// - Counters are sized to max(TURN_CYCLES,DRIVE_CYCLES,SYNC_STAGES). They load at state entry and count down to 1; no wrap.
// - A reset mid-TURN/DRIVE/SAMPLE aborts the transfer with no rsp_valid. The next request after reset sees dir=RELEASED.
// TESTING
// - Reset, then write 0xA5: pad_t=1 for 2 cycles, pad_t=0 and pad_i=0xA5 at E0+2, rsp_valid pulse at E0+4, rdata=0.
// - Write 0x3C right after the above: no turnaround, pad_i=0x3C at E0, rsp_valid at E0+2, pad_t stays 0 throughout.
// - Read with pad_o=0x5A after a write: pad_t=1 at E0, rsp_valid at E0+4, rsp_rdata=0x5A.
// - Back-to-back reads: second rsp_valid at E0+2. pad_o toggling 0x00->0xFF one cycle before capture yields 0x00; toggling 3 cycles before yields 0xFF.
// - Hold req_valid across a busy period: exactly one accept per IDLE, req_ready=0 from E0 through RESP, no request lost or duplicated.
// - Assert rst_n=0 mid-DRIVE: pad_t=1 and pad_i=0 asynchronously, no rsp_valid; the next write takes the TURN path (E0+4 ack).

Source files
------------

// File: rtl/iobuf_bus_sequencer.sv
// iobuf_bus_sequencer
// Logic-side controller for a bidirectional pad bus made of per-bit tri-state
// IO buffers. Converts single read/write requests into bus cycles, inserts
// released-bus turnaround gaps on direction changes, and synchronises the
// asynchronous pad readback before it is ever used.
module iobuf_bus_sequencer #(
   parameter int WIDTH        = 8,
   parameter int TURN_CYCLES  = 2,
   parameter int DRIVE_CYCLES = 2,
   parameter int SYNC_STAGES  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             rsp_valid,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic [WIDTH-1:0] pad_i,
   output logic             pad_t,
   input  logic [WIDTH-1:0] pad_o
);

   localparam int MAX_TD  = (TURN_CYCLES > DRIVE_CYCLES) ? TURN_CYCLES : DRIVE_CYCLES;
   localparam int MAX_CNT = (MAX_TD > SYNC_STAGES) ? MAX_TD : SYNC_STAGES;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   localparam logic [CNT_W-1:0] TURN_LOAD  = CNT_W'(TURN_CYCLES);
   localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(DRIVE_CYCLES);
   localparam logic [CNT_W-1:0] SYNC_LOAD  = CNT_W'(SYNC_STAGES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TURN,
      S_DRIVE,
      S_SAMPLE,
      S_RESP
   } state_t;

   // dir: 1 = this end is driving the bus, 0 = bus released
   state_t             state_q,     state_d;
   logic               dir_q,       dir_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic               write_q,     write_d;
   logic [WIDTH-1:0]   wdata_q,     wdata_d;
   logic [WIDTH-1:0]   pad_i_q,     pad_i_d;
   logic               pad_t_q,     pad_t_d;
   logic               req_ready_q, req_ready_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
   logic [WIDTH-1:0]   sync_d [SYNC_STAGES];

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign pad_i     = pad_i_q;
   assign pad_t     = pad_t_q;

   // Shift chain for the asynchronous pad readback
   always_comb begin
      sync_d[0] = pad_o;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   // Sequencer next-state: accept, turnaround, drive hold, sample wait, response
   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      cnt_d       = cnt_q;
      write_d     = write_q;
      wdata_d     = wdata_q;
      pad_i_d     = pad_i_q;
      pad_t_d     = pad_t_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               write_d     = req_write;
               wdata_d     = req_wdata;
               if (req_write) begin
                  if (dir_q) begin
                     // Already driving: new data goes straight onto the bus
                     pad_i_d = req_wdata;
                     state_d = S_DRIVE;
                     cnt_d   = DRIVE_LOAD;
                  end else begin
                     // Let the far end get off the bus before we drive
                     state_d = S_TURN;
                     cnt_d   = TURN_LOAD;
                  end
               end else begin
                  if (dir_q) begin
                     // Release immediately, then wait out the turnaround
                     pad_t_d = 1'b1;
                     dir_d   = 1'b0;
                     state_d = S_TURN;
                     cnt_d   = TURN_LOAD;
                  end else begin
                     state_d = S_SAMPLE;
                     cnt_d   = SYNC_LOAD;
                  end
               end
            end
         end

         S_TURN: begin
            if (cnt_q > CNT_ONE) begin
               cnt_d = cnt_q - CNT_ONE;
            end else if (write_q) begin
               pad_i_d = wdata_q;
               pad_t_d = 1'b0;
               dir_d   = 1'b1;
               state_d = S_DRIVE;
               cnt_d   = DRIVE_LOAD;
            end else begin
               state_d = S_SAMPLE;
               cnt_d   = SYNC_LOAD;
            end
         end

         S_DRIVE: begin
            if (cnt_q > CNT_ONE) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
            end
         end

         S_SAMPLE: begin
            if (cnt_q > CNT_ONE) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = sync_q[SYNC_STAGES-1];
            end
         end

         S_RESP: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
         end

         default: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers; reset releases the bus at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         dir_q       <= 1'b0;
         cnt_q       <= '0;
         write_q     <= 1'b0;
         wdata_q     <= '0;
         pad_i_q     <= '0;
         pad_t_q     <= 1'b1;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         cnt_q       <= cnt_d;
         write_q     <= write_d;
         wdata_q     <= wdata_d;
         pad_i_q     <= pad_i_d;
         pad_t_q     <= pad_t_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // pad_o synchroniser flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
      end
   end

endmodule

// File: tb/tb_iobuf_bus_sequencer.sv
// Bench for iobuf_bus_sequencer: directed requests, scoreboard of expected
// responses (cycle and data), plus direct pad/handshake checks.
module tb_iobuf_bus_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic [7:0] pad_i;
   logic       pad_t;
   logic [7:0] pad_o;

   iobuf_bus_sequencer #(
      .WIDTH(8), .TURN_CYCLES(2), .DRIVE_CYCLES(2), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .pad_i(pad_i), .pad_t(pad_t), .pad_o(pad_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   acc_cnt = 0;
   int   nvec = 0;
   int   nmis = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (rst_n && req_valid && req_ready) acc_cnt <= acc_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: pop and compare every response the DUT presents
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && rsp_valid) begin
         if (sb.size() == 0) begin
            nvec++;
            nmis++;
            $display("FAIL rsp_unexpected @cycle %0d: got rsp rdata %0h expected no response", cyc, rsp_rdata);
         end else begin
            e = sb.pop_front();
            chk("rsp_cycle", cyc, e.cyc);
            chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.data});
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_until(input int n);
      int g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (cyc < n && g < 200);
      if (cyc != n) chk("wait_until", cyc, n);
   endtask

   task automatic wait_idle();
      int g = 0;
      @(negedge clk);
      while (!req_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (!req_ready) chk("idle_timeout", req_ready, 1);
   endtask

   // Present a request; returns the accept cycle. Optionally queue the response.
   task automatic issue(input logic w, input logic [7:0] d, input bit push,
                        input int lat, input logic [7:0] rd, output int e0);
      int g = 0;
      req_valid = 1'b1;
      req_write = w;
      req_wdata = d;
      while (!req_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (!req_ready) chk("accept_timeout", req_ready, 1);
      @(posedge clk);
      #1;
      e0 = cyc;
      if (push) sb.push_back('{e0 + lat, rd});
      req_valid = 1'b0;
   endtask

   initial begin
      int e0;
      int a0;
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_wdata = 8'h00;
      pad_o = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_pad_t", pad_t, 1);
      chk("rst_pad_i", pad_i, 8'h00);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);

      // Write 0xA5 from released bus: turnaround path
      issue(1'b1, 8'hA5, 1'b1, 4, 8'h00, e0);
      wait_until(e0);
      chk("wrA5_t_e0", pad_t, 1);
      chk("wrA5_ready_e0", req_ready, 0);
      wait_until(e0 + 1);
      chk("wrA5_t_e1", pad_t, 1);
      wait_until(e0 + 2);
      chk("wrA5_t_e2", pad_t, 0);
      chk("wrA5_i_e2", pad_i, 8'hA5);
      wait_idle();

      // Write 0x3C while driving: no turnaround
      issue(1'b1, 8'h3C, 1'b1, 2, 8'h00, e0);
      chk("wr3C_i_e0", pad_i, 8'h3C);
      chk("wr3C_t_e0", pad_t, 0);
      wait_until(e0 + 1);
      chk("wr3C_t_e1", pad_t, 0);
      wait_until(e0 + 2);
      chk("wr3C_t_e2", pad_t, 0);
      wait_idle();

      // Read after write: release at accept, data 0x5A
      pad_o = 8'h5A;
      issue(1'b0, 8'h00, 1'b1, 4, 8'h5A, e0);
      chk("rd5A_t_e0", pad_t, 1);
      wait_until(e0 + 2);
      chk("rd5A_i_hold", pad_i, 8'h3C);
      wait_idle();

      // Back-to-back reads; pad_o changes one cycle before capture
      pad_o = 8'h00;
      repeat (3) @(negedge clk);
      issue(1'b0, 8'h00, 1'b1, 2, 8'h00, e0);
      wait_until(e0 + 1);
      pad_o = 8'hFF;
      wait_idle();
      // pad_o changes three cycles before capture
      pad_o = 8'h00;
      repeat (3) @(negedge clk);
      pad_o = 8'hFF;
      issue(1'b0, 8'h00, 1'b1, 2, 8'hFF, e0);
      wait_idle();

      // Held req_valid across a busy period: two distinct requests, one accept each
      a0 = acc_cnt;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_wdata = 8'h11;
      @(posedge clk);
      #1;
      e0 = cyc;
      sb.push_back('{e0 + 4, 8'h00});
      req_wdata = 8'h22;
      for (int k = 0; k <= 4; k++) begin
         wait_until(e0 + k);
         chk("hold_ready_busy", req_ready, 0);
      end
      chk("hold_acc_first", acc_cnt - a0, 1);
      wait_until(e0 + 5);
      chk("hold_ready_idle", req_ready, 1);
      @(posedge clk);
      #1;
      sb.push_back('{e0 + 8, 8'h00});
      req_valid = 1'b0;
      wait_until(e0 + 6);
      chk("hold_i_second", pad_i, 8'h22);
      chk("hold_t_second", pad_t, 0);
      wait_idle();
      repeat (2) @(negedge clk);
      chk("hold_acc_total", acc_cnt - a0, 2);

      // Reset during DRIVE: async release, no response
      issue(1'b1, 8'h77, 1'b0, 0, 8'h00, e0);
      chk("rstm_i_pre", pad_i, 8'h77);
      chk("rstm_t_pre", pad_t, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstm_t_async", pad_t, 1);
      chk("rstm_i_async", pad_i, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("rstm_no_rsp", rsp_valid, 0);

      // Next write after reset takes the turnaround path
      issue(1'b1, 8'h99, 1'b1, 4, 8'h00, e0);
      wait_until(e0 + 1);
      chk("post_t_e1", pad_t, 1);
      wait_until(e0 + 2);
      chk("post_t_e2", pad_t, 0);
      chk("post_i_e2", pad_i, 8'h99);
      wait_idle();
      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
